pcie_cpl_tlp_mux: RTL and testbench
===================================

Name: pcie_cpl_tlp_mux

Overview:
Packet-granular N-to-1 multiplexer for completion TLP streams. Merges PORTS independent completion sources (e.g. several AXI-read engines) onto the single tx_cpl_tlp interface toward the PCIe core. Arbitration is round-robin and locks a grant for a whole TLP, sop through eop. A registered output stage with a skid buffer keeps every ready path free of combinational through-paths.

Parameters:
PORTS, 4, number of input completion channels (2..16)
DATA_WIDTH, 256, TLP payload bits per beat
STRB_WIDTH, DATA_WIDTH/32, dword strobe bits per beat
HDR_WIDTH, 128, TLP header bits, valid on the sop beat
CNT_WIDTH, 32, width of each statistics counter (optional feature only)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, asynchronous, active-high
in_tlp_data  in  PORTS*DATA_WIDTH  per-port payload, port i at [i*DATA_WIDTH +: DATA_WIDTH]
in_tlp_strb  in  PORTS*STRB_WIDTH  per-port dword strobes
in_tlp_hdr  in  PORTS*HDR_WIDTH  per-port header
in_tlp_valid  in  PORTS  per-port beat valid
in_tlp_sop  in  PORTS  per-port start of packet
in_tlp_eop  in  PORTS  per-port end of packet
in_tlp_ready  out  PORTS  per-port beat accept
tx_cpl_tlp_data  out  DATA_WIDTH  merged payload
tx_cpl_tlp_strb  out  STRB_WIDTH  merged strobes
tx_cpl_tlp_hdr  out  HDR_WIDTH  merged header
tx_cpl_tlp_valid  out  1  output beat valid
tx_cpl_tlp_sop  out  1  output start of packet
tx_cpl_tlp_eop  out  1  output end of packet
tx_cpl_tlp_ready  in  1  sink accept
drop_pulse  out  1  one-cycle pulse when an orphan beat is discarded

Behaviour:
- Reset (asynchronous, active-high): all tx_cpl_tlp_* outputs 0. drop_pulse 0. in_tlp_ready 0. State IDLE. Skid empty. Round-robin pointer = 0.
- A beat transfers on either side when valid and ready are both 1 at posedge clk.
- FSM state IDLE:
  - Candidates are ports with valid&sop.
  - Grant the first candidate searching from the pointer upward, wrapping at PORTS-1 back to 0.
  - Grant is combinational. The granted port's first beat is accepted in the same cycle if the stage can take it.
  - On grant, the pointer becomes granted+1 mod PORTS.
  - If the accepted beat has eop=1, stay in IDLE (back-to-back single-beat TLPs allowed). Otherwise go to BUSY.
- FSM state BUSY:
  - Only the granted port may see ready=1. All other ports see ready=0.
  - Return to IDLE on the cycle the granted port's eop beat is accepted.
  - Arbitration resumes in that same cycle only for the next cycle's requests; there is no same-cycle regrant.
- Orphan beat (IDLE only): a port with valid=1, sop=0 gets ready=1 and the beat is discarded. drop_pulse=1 for that cycle. At most one orphan per cycle is discarded, chosen as the lowest index. Orphan discard never blocks a grant in the same cycle.
- Output stage: main output register plus a one-entry skid register.
  - in_tlp_ready[granted] = ~skid_valid, driven from a flop.
  - Latency is 1 cycle from input accept to tx_cpl_tlp_valid when the stage is empty.
  - When tx_cpl_tlp_ready=0 and the main register is full, an accepted beat goes to the skid register. ready deasserts the next cycle.
  - When the sink accepts, the skid entry moves to main ahead of any new beat.
- Beat order within a packet is preserved. Packets are never interleaved on the output.
- hdr/sop pass through unmodified with their beat; no header rewriting.
- Full throughput: one beat per cycle sustained while tx_cpl_tlp_ready=1.
- Reset mid-packet: the packet is abandoned and the output is cleared immediately. The source must restart with a sop beat, otherwise it is treated as an orphan.

Optional Feature:
PCIE_CPL_MUX_STATS_EN
- Defined: adds output stat_pkt_count, width PORTS*CNT_WIDTH.
  - Holds per-port counters of accepted eop beats.
  - Counters wrap modulo 2^CNT_WIDTH and are cleared by rst.
  - Orphan beats are not counted.
- Not defined: port and counters absent. All other behaviour is identical.

Test Plan:
- PORTS=4, ports 0..3 each present a 3-beat TLP at the same time, sink always ready -> output order is 0,1,2,3; 12 beats in 12 consecutive cycles after a 1-cycle latency; no interleave.
- Port 2 sends a 1-beat TLP (sop=eop=1) with data=0xA5.., streamed back-to-back 8 times, other ports idle -> 8 consecutive output beats; pointer advances to 3 each time and port 2 is re-granted.
- 4-beat TLP on port 1, tx_cpl_tlp_ready held 0 for cycles 2..5 -> at most 2 beats buffered, in_tlp_ready[1]=0 from cycle 3; all 4 beats delivered in order once ready=1; no beat lost or duplicated.
- Port 3 asserts valid=1, sop=0 in IDLE with data 0xDEAD -> beat discarded, drop_pulse=1 for exactly 1 cycle, tx_cpl_tlp_valid stays 0.
- rst asserted asynchronously mid-beat 2 of a 4-beat TLP -> all outputs 0 immediately; after release, port 0 TLP with sop is granted first.
- With PCIE_CPL_MUX_STATS_EN defined, 5 TLPs on port 0 and 3 on port 1 -> stat_pkt_count = {…,3,5}; with the macro undefined the bench compiles without the port.

Source files
------------

// File: rtl/pcie_cpl_tlp_mux.sv
// rtl/pcie_cpl_tlp_mux.sv - round-robin packet-locked N-to-1 completion TLP mux with registered skid output
// Optional PCIE_CPL_MUX_STATS_EN adds per-port accepted-eop counters on stat_pkt_count.
module pcie_cpl_tlp_mux #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 256,
    parameter int STRB_WIDTH = DATA_WIDTH / 32,
    parameter int HDR_WIDTH  = 128,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] in_tlp_data,
    input  logic [PORTS*STRB_WIDTH-1:0] in_tlp_strb,
    input  logic [PORTS*HDR_WIDTH-1:0]  in_tlp_hdr,
    input  logic [PORTS-1:0]            in_tlp_valid,
    input  logic [PORTS-1:0]            in_tlp_sop,
    input  logic [PORTS-1:0]            in_tlp_eop,
    output logic [PORTS-1:0]            in_tlp_ready,
    output logic [DATA_WIDTH-1:0]       tx_cpl_tlp_data,
    output logic [STRB_WIDTH-1:0]       tx_cpl_tlp_strb,
    output logic [HDR_WIDTH-1:0]        tx_cpl_tlp_hdr,
    output logic                        tx_cpl_tlp_valid,
    output logic                        tx_cpl_tlp_sop,
    output logic                        tx_cpl_tlp_eop,
    input  logic                        tx_cpl_tlp_ready,
    output logic                        drop_pulse
`ifdef PCIE_CPL_MUX_STATS_EN
    ,
    output logic [PORTS*CNT_WIDTH-1:0]  stat_pkt_count
`endif
);

    localparam int          PW    = $clog2(PORTS);
    localparam logic [PW:0] NPORT = (PW + 1)'(PORTS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   rr_ptr, rr_ptr_nxt, gnt, gnt_nxt, sel, idx;
    logic [PW:0]     sum;
    logic            found, orphan_found, sel_en, in_fire;

    logic [DATA_WIDTH-1:0] data_arr [PORTS];
    logic [STRB_WIDTH-1:0] strb_arr [PORTS];
    logic [HDR_WIDTH-1:0]  hdr_arr  [PORTS];

    logic                  skid_valid, skid_sop, skid_eop;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [STRB_WIDTH-1:0] skid_strb;
    logic [HDR_WIDTH-1:0]  skid_hdr;

    for (genvar p = 0; p < PORTS; p++) begin : g_unpack
        assign data_arr[p] = in_tlp_data[p*DATA_WIDTH +: DATA_WIDTH];
        assign strb_arr[p] = in_tlp_strb[p*STRB_WIDTH +: STRB_WIDTH];
        assign hdr_arr[p]  = in_tlp_hdr[p*HDR_WIDTH +: HDR_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            gnt    <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            gnt    <= gnt_nxt;
        end
    end

    // Ready depends only on state, request lines and the skid flop, never on tx_cpl_tlp_ready.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        gnt_nxt      = gnt;
        sel          = gnt;
        sel_en       = 1'b0;
        found        = 1'b0;
        orphan_found = 1'b0;
        in_tlp_ready = '0;
        drop_pulse   = 1'b0;
        sum          = '0;
        idx          = '0;
        if (!rst) begin
            if (state == IDLE) begin
                for (int i = 0; i < PORTS; i++) begin
                    sum = {1'b0, rr_ptr} + (PW + 1)'(i);
                    if (sum >= NPORT) sum = sum - NPORT;
                    idx = sum[PW-1:0];
                    if (!found && in_tlp_valid[idx] && in_tlp_sop[idx]) begin
                        found = 1'b1;
                        sel   = idx;
                    end
                end
                if (found && !skid_valid) begin
                    sel_en            = 1'b1;
                    in_tlp_ready[sel] = 1'b1;
                    gnt_nxt           = sel;
                    rr_ptr_nxt        = ({1'b0, sel} == NPORT - 1'b1) ? '0 : sel + 1'b1;
                    if (!in_tlp_eop[sel]) state_nxt = BUSY;
                end
                // Orphans never carry sop, so they cannot collide with the granted port.
                for (int i = 0; i < PORTS; i++) begin
                    if (!orphan_found && in_tlp_valid[i] && !in_tlp_sop[i]) begin
                        orphan_found    = 1'b1;
                        in_tlp_ready[i] = 1'b1;
                        drop_pulse      = 1'b1;
                    end
                end
            end else if (!skid_valid) begin
                sel_en            = 1'b1;
                in_tlp_ready[gnt] = 1'b1;
                if (in_tlp_valid[gnt] && in_tlp_eop[gnt]) state_nxt = IDLE;
            end
        end
    end

    assign in_fire = sel_en && in_tlp_valid[sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cpl_tlp_valid <= 1'b0;
            tx_cpl_tlp_data  <= '0;
            tx_cpl_tlp_strb  <= '0;
            tx_cpl_tlp_hdr   <= '0;
            tx_cpl_tlp_sop   <= 1'b0;
            tx_cpl_tlp_eop   <= 1'b0;
            skid_valid       <= 1'b0;
            skid_data        <= '0;
            skid_strb        <= '0;
            skid_hdr         <= '0;
            skid_sop         <= 1'b0;
            skid_eop         <= 1'b0;
        end else if (!tx_cpl_tlp_valid || tx_cpl_tlp_ready) begin
            if (skid_valid) begin
                tx_cpl_tlp_valid <= 1'b1;
                tx_cpl_tlp_data  <= skid_data;
                tx_cpl_tlp_strb  <= skid_strb;
                tx_cpl_tlp_hdr   <= skid_hdr;
                tx_cpl_tlp_sop   <= skid_sop;
                tx_cpl_tlp_eop   <= skid_eop;
                skid_valid       <= 1'b0;
            end else if (in_fire) begin
                tx_cpl_tlp_valid <= 1'b1;
                tx_cpl_tlp_data  <= data_arr[sel];
                tx_cpl_tlp_strb  <= strb_arr[sel];
                tx_cpl_tlp_hdr   <= hdr_arr[sel];
                tx_cpl_tlp_sop   <= in_tlp_sop[sel];
                tx_cpl_tlp_eop   <= in_tlp_eop[sel];
            end else begin
                tx_cpl_tlp_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= data_arr[sel];
            skid_strb  <= strb_arr[sel];
            skid_hdr   <= hdr_arr[sel];
            skid_sop   <= in_tlp_sop[sel];
            skid_eop   <= in_tlp_eop[sel];
        end
    end

`ifdef PCIE_CPL_MUX_STATS_EN
    logic [CNT_WIDTH-1:0] pkt_cnt [PORTS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < PORTS; p++) pkt_cnt[p] <= '0;
        end else if (in_fire && in_tlp_eop[sel]) begin
            pkt_cnt[sel] <= pkt_cnt[sel] + 1'b1;
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_stat
        assign stat_pkt_count[p*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt[p];
    end
`endif

endmodule

// File: tb/tb_pcie_cpl_tlp_mux.sv
// tb/tb_pcie_cpl_tlp_mux.sv - scoreboard bench for pcie_cpl_tlp_mux
// Covers PCIE_CPL_MUX_STATS_EN counters when that macro is defined.
module tb_pcie_cpl_tlp_mux;

    localparam int PORTS = 4;
    localparam int DW    = 256;
    localparam int SW    = 8;
    localparam int HW    = 128;
    localparam int CW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [PORTS*DW-1:0] in_tlp_data;
    logic [PORTS*SW-1:0] in_tlp_strb;
    logic [PORTS*HW-1:0] in_tlp_hdr;
    logic [PORTS-1:0]    in_tlp_valid, in_tlp_sop, in_tlp_eop, in_tlp_ready;
    logic [DW-1:0]       tx_cpl_tlp_data;
    logic [SW-1:0]       tx_cpl_tlp_strb;
    logic [HW-1:0]       tx_cpl_tlp_hdr;
    logic                tx_cpl_tlp_valid, tx_cpl_tlp_sop, tx_cpl_tlp_eop;
    logic                sink_ready;
    logic                drop_pulse;
`ifdef PCIE_CPL_MUX_STATS_EN
    logic [PORTS*CW-1:0] stat_pkt_count;
`endif

    logic [DW-1:0] drv_data  [PORTS];
    logic [SW-1:0] drv_strb  [PORTS];
    logic [HW-1:0] drv_hdr   [PORTS];
    logic          drv_valid [PORTS];
    logic          drv_sop   [PORTS];
    logic          drv_eop   [PORTS];

    for (genvar p = 0; p < PORTS; p++) begin : g_pack
        assign in_tlp_data[p*DW +: DW] = drv_data[p];
        assign in_tlp_strb[p*SW +: SW] = drv_strb[p];
        assign in_tlp_hdr[p*HW +: HW]  = drv_hdr[p];
        assign in_tlp_valid[p]         = drv_valid[p];
        assign in_tlp_sop[p]           = drv_sop[p];
        assign in_tlp_eop[p]           = drv_eop[p];
    end

    pcie_cpl_tlp_mux #(
        .PORTS(PORTS), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .HDR_WIDTH(HW), .CNT_WIDTH(CW)
    ) dut (
`ifdef PCIE_CPL_MUX_STATS_EN
        .stat_pkt_count   (stat_pkt_count),
`endif
        .clk              (clk),
        .rst              (rst),
        .in_tlp_data      (in_tlp_data),
        .in_tlp_strb      (in_tlp_strb),
        .in_tlp_hdr       (in_tlp_hdr),
        .in_tlp_valid     (in_tlp_valid),
        .in_tlp_sop       (in_tlp_sop),
        .in_tlp_eop       (in_tlp_eop),
        .in_tlp_ready     (in_tlp_ready),
        .tx_cpl_tlp_data  (tx_cpl_tlp_data),
        .tx_cpl_tlp_strb  (tx_cpl_tlp_strb),
        .tx_cpl_tlp_hdr   (tx_cpl_tlp_hdr),
        .tx_cpl_tlp_valid (tx_cpl_tlp_valid),
        .tx_cpl_tlp_sop   (tx_cpl_tlp_sop),
        .tx_cpl_tlp_eop   (tx_cpl_tlp_eop),
        .tx_cpl_tlp_ready (sink_ready),
        .drop_pulse       (drop_pulse)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [HW-1:0] hdr;
        logic [SW-1:0] strb;
        logic          sop;
        logic          eop;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    out_cyc[$];
    int    n_cmp   = 0;
    int    n_err   = 0;
    int    cyc     = 0;
    int    acc_cnt = 0;
    int    pop_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic beat_t mk_beat(input int p, input int n, input logic [15:0] tag, input int b);
        beat_t       r;
        logic [31:0] w;
        w      = {8'(p), tag, 8'(b)};
        r.data = {8{w}};
        r.hdr  = {4{~w}};
        r.strb = (b == n - 1) ? 8'h0F : 8'hFF;
        r.sop  = (b == 0);
        r.eop  = (b == n - 1);
        return r;
    endfunction

    task automatic push_pkt(input int p, input int n, input logic [15:0] tag);
        for (int b = 0; b < n; b++) exp_q.push_back(mk_beat(p, n, tag, b));
    endtask

    task automatic drive_beat(input int p, input beat_t b);
        drv_data[p]  = b.data;
        drv_hdr[p]   = b.hdr;
        drv_strb[p]  = b.strb;
        drv_sop[p]   = b.sop;
        drv_eop[p]   = b.eop;
        drv_valid[p] = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the last beat is taken.
    task automatic send_pkt(input int p, input int n, input logic [15:0] tag);
        logic acc;
        int   waitc;
        for (int k = 0; k < n; k++) begin
            drive_beat(p, mk_beat(p, n, tag, k));
            acc   = 1'b0;
            waitc = 0;
            while (!acc && waitc < 500) begin
                @(negedge clk);
                acc = in_tlp_ready[p];
                @(posedge clk);
                waitc++;
            end
            if (!acc) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout port=%0d beat=%0d actual=no_ready required=ready", p, k);
            end else begin
                acc_cnt++;
            end
            #1;
        end
        drv_valid[p] = 1'b0;
        drv_sop[p]   = 1'b0;
        drv_eop[p]   = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_left", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && tx_cpl_tlp_valid && sink_ready) begin
            pop_cnt++;
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat actual=%0h required=none", tx_cpl_tlp_data[31:0]);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_data", tx_cpl_tlp_data, mon_e.data);
                chk("out_ctl", {tx_cpl_tlp_hdr, tx_cpl_tlp_strb, tx_cpl_tlp_sop, tx_cpl_tlp_eop},
                    {mon_e.hdr, mon_e.strb, mon_e.sop, mon_e.eop});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    int   c0, acc0, pop0, occ, max_occ;
    logic rdy_log [10];

    initial begin
        for (int p = 0; p < PORTS; p++) begin
            drv_data[p] = '0; drv_strb[p] = '0; drv_hdr[p] = '0;
            drv_valid[p] = 1'b0; drv_sop[p] = 1'b0; drv_eop[p] = 1'b0;
        end
        sink_ready = 1'b1;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_valid", tx_cpl_tlp_valid, 0);
        chk("rst_tx_data", tx_cpl_tlp_data, 0);
        chk("rst_tx_sop_eop", {tx_cpl_tlp_sop, tx_cpl_tlp_eop}, 0);
        chk("rst_in_ready", in_tlp_ready, 0);
        chk("rst_drop", drop_pulse, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All four ports raise a 3-beat TLP together.
        for (int p = 0; p < PORTS; p++) push_pkt(p, 3, 16'h1000 + 16'(p));
        out_cyc.delete();
        c0 = cyc;
        fork
            send_pkt(0, 3, 16'h1000);
            send_pkt(1, 3, 16'h1001);
            send_pkt(2, 3, 16'h1002);
            send_pkt(3, 3, 16'h1003);
        join
        wait_drain();
        chk("t1_count", out_cyc.size(), 12);
        chk("t1_latency", out_cyc[0] - c0, 1);
        chk("t1_span", out_cyc[11] - out_cyc[0], 11);

        // Eight back-to-back single-beat TLPs on port 2.
        for (int k = 0; k < 8; k++) push_pkt(2, 1, 16'hA5A0 + 16'(k));
        out_cyc.delete();
        c0 = cyc;
        for (int k = 0; k < 8; k++) send_pkt(2, 1, 16'hA5A0 + 16'(k));
        wait_drain();
        chk("t2_count", out_cyc.size(), 8);
        chk("t2_latency", out_cyc[0] - c0, 1);
        chk("t2_span", out_cyc[7] - out_cyc[0], 7);

        // Backpressure: sink stalls while a 4-beat TLP from port 1 is in flight.
        push_pkt(1, 4, 16'h3000);
        acc0    = acc_cnt;
        pop0    = pop_cnt;
        max_occ = 0;
        fork
            send_pkt(1, 4, 16'h3000);
            begin
                @(posedge clk); #1 sink_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 sink_ready = 1'b1;
            end
            begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    #1;
                    rdy_log[k] = in_tlp_ready[1];
                    occ = (acc_cnt - acc0) - (pop_cnt - pop0) + ((tx_cpl_tlp_valid && sink_ready) ? 1 : 0);
                    if (occ > max_occ) max_occ = occ;
                end
            end
        join
        wait_drain();
        chk("t3_ready_c1", rdy_log[1], 1'b1);
        chk("t3_ready_stall", {rdy_log[2], rdy_log[3], rdy_log[4], rdy_log[5]}, 4'b0000);
        chk("t3_ready_resume", rdy_log[6], 1'b1);
        chk("t3_max_buffered", max_occ, 2);
        chk("t3_delivered", pop_cnt - pop0, 4);

        // Orphan beat on port 3 while idle.
        pop0 = pop_cnt;
        drive_beat(3, '{data: 256'hDEAD, hdr: '0, strb: 8'hFF, sop: 1'b0, eop: 1'b0});
        @(negedge clk);
        #1;
        chk("t4_drop_on", drop_pulse, 1'b1);
        chk("t4_ready3", in_tlp_ready[3], 1'b1);
        @(posedge clk);
        #1 drv_valid[3] = 1'b0;
        @(negedge clk);
        chk("t4_drop_off", drop_pulse, 1'b0);
        repeat (3) @(negedge clk);
        chk("t4_no_output", pop_cnt - pop0, 0);
        chk("t4_tx_valid", tx_cpl_tlp_valid, 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a 4-beat TLP on port 0.
        exp_q.push_back(mk_beat(0, 4, 16'h5000, 0));
        exp_q.push_back(mk_beat(0, 4, 16'h5000, 1));
        drive_beat(0, mk_beat(0, 4, 16'h5000, 0));
        @(posedge clk);
        #1 drive_beat(0, mk_beat(0, 4, 16'h5000, 1));
        @(posedge clk);
        #1 drive_beat(0, mk_beat(0, 4, 16'h5000, 2));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t5_tx_valid", tx_cpl_tlp_valid, 1'b0);
        chk("t5_tx_data", tx_cpl_tlp_data, 0);
        chk("t5_tx_sop_eop", {tx_cpl_tlp_sop, tx_cpl_tlp_eop}, 0);
        chk("t5_in_ready", in_tlp_ready, 0);
        chk("t5_pre_rst_beats", exp_q.size(), 0);
        push_pkt(0, 2, 16'h5100);
        push_pkt(1, 1, 16'h5200);
        @(posedge clk);
        #1;
        fork
            send_pkt(0, 2, 16'h5100);
            send_pkt(1, 1, 16'h5200);
            begin
                @(negedge clk);
                #1;
                chk("t5_ready_in_rst", in_tlp_ready, 0);
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        wait_drain();

`ifdef PCIE_CPL_MUX_STATS_EN
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("st_cleared", stat_pkt_count, 0);
        for (int k = 0; k < 5; k++) begin
            push_pkt(0, 2, 16'h6000 + 16'(k));
            send_pkt(0, 2, 16'h6000 + 16'(k));
        end
        for (int k = 0; k < 3; k++) begin
            push_pkt(1, 1, 16'h6100 + 16'(k));
            send_pkt(1, 1, 16'h6100 + 16'(k));
        end
        wait_drain();
        chk("st_port0", stat_pkt_count[0 +: CW], 5);
        chk("st_port1", stat_pkt_count[CW +: CW], 3);
        chk("st_port23", stat_pkt_count[2*CW +: 2*CW], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
